// File: rtl/snake_if.sv
// snake_if: control, status and render-query signals between the snake engine and its surroundings
interface snake_if #(
    parameter int XW = 6,
    parameter int YW = 5,
    parameter int LW = 5
);
    logic [1:0]    game_status;
    logic          restart;
    logic          key1_press;
    logic          key2_press;
    logic          key3_press;
    logic          key4_press;
    logic          grow;
    logic          hit_wall;
    logic          hit_body;
    logic [XW-1:0] head_x;
    logic [YW-1:0] head_y;
    logic [LW-1:0] snake_len;
    logic          move_tick;
    logic [XW-1:0] query_x;
    logic [YW-1:0] query_y;
    logic          query_hit;
    modport master (
        output game_status, restart, key1_press, key2_press, key3_press, key4_press, grow, query_x, query_y,
        input  hit_wall, hit_body, head_x, head_y, snake_len, move_tick, query_hit
    );
    modport slave (
        input  game_status, restart, key1_press, key2_press, key3_press, key4_press, grow, query_x, query_y,
        output hit_wall, hit_body, head_x, head_y, snake_len, move_tick, query_hit
    );
endinterface

// File: rtl/snake_motion_ctrl.sv
// snake_motion_ctrl: segment list, tick-driven stepping, wall/body collision and registered cell-occupancy query
module snake_motion_ctrl #(
    parameter int GRID_W     = 40,
    parameter int GRID_H     = 30,
    parameter int MAX_LEN    = 16,
    parameter int INIT_LEN   = 3,
    parameter int MOVE_TICKS = 12_500_000,
    parameter int XW         = 6,
    parameter int YW         = 5,
    parameter int LW         = 5
) (
    input logic CLK_50M,
    input logic RST,
    snake_if.slave bus
);
    typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;
    localparam int TW = $clog2(MOVE_TICKS + 1);
    localparam logic [1:0] PLAY = 2'b10;
    localparam logic [1:0] DIE  = 2'b11;
    logic [XW-1:0] r_seg_x [MAX_LEN];
    logic [YW-1:0] r_seg_y [MAX_LEN];
    logic [LW-1:0] r_len;
    logic [TW-1:0] r_tick;
    dir_t          r_cur_dir, r_next_dir, w_req_dir, w_base_dir;
    logic          r_pending, r_hit_wall, r_hit_body, r_move_tick, r_query_hit;
    logic          w_run, w_step, w_wall, w_body, w_move, w_any_key, w_key_ok, w_query;
    logic [XW-1:0] w_nx;
    logic [YW-1:0] w_ny;

    always_comb begin
        w_run = bus.game_status == PLAY && !r_hit_wall && !r_hit_body;
        w_step = w_run && r_tick == TW'(MOVE_TICKS - 1);
        w_nx = r_next_dir == LEFT ? r_seg_x[0] - XW'(1) : r_next_dir == RIGHT ? r_seg_x[0] + XW'(1) : r_seg_x[0];
        w_ny = r_next_dir == UP ? r_seg_y[0] - YW'(1) : r_next_dir == DOWN ? r_seg_y[0] + YW'(1) : r_seg_y[0];
        w_wall = (r_next_dir == LEFT && r_seg_x[0] == '0) || (r_next_dir == RIGHT && r_seg_x[0] == XW'(GRID_W - 1)) ||
                 (r_next_dir == UP && r_seg_y[0] == '0) || (r_next_dir == DOWN && r_seg_y[0] == YW'(GRID_H - 1));
        w_body = 1'b0;
        w_query = 1'b0;
        // The tail vacates its cell on a normal step, so it only blocks when this step grows
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((i + 1 < int'(r_len) || (i + 1 == int'(r_len) && r_pending && int'(r_len) < MAX_LEN)) &&
                r_seg_x[i] == w_nx && r_seg_y[i] == w_ny) w_body = 1'b1;
            if (i < int'(r_len) && r_seg_x[i] == bus.query_x && r_seg_y[i] == bus.query_y) w_query = 1'b1;
        end
        w_move = w_step && !w_wall && !w_body;
        w_any_key = bus.key1_press || bus.key2_press || bus.key3_press || bus.key4_press;
        w_req_dir = bus.key1_press ? UP : bus.key2_press ? DOWN : bus.key3_press ? LEFT : RIGHT;
        // Reversal is judged against the direction that will be committed after this edge
        w_base_dir = w_move ? r_next_dir : r_cur_dir;
        w_key_ok = w_any_key && bus.game_status != DIE && w_req_dir != dir_t'({w_base_dir[1], ~w_base_dir[0]});
    end

    always_ff @(posedge CLK_50M) begin
        if (RST || bus.restart) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= XW'(GRID_W / 2 - i);
                r_seg_y[i] <= YW'(GRID_H / 2);
            end
            r_len       <= LW'(INIT_LEN);
            r_tick      <= '0;
            r_cur_dir   <= RIGHT;
            r_next_dir  <= RIGHT;
            r_pending   <= 1'b0;
            r_hit_wall  <= 1'b0;
            r_hit_body  <= 1'b0;
            r_move_tick <= 1'b0;
            r_query_hit <= 1'b0;
        end else begin
            r_tick      <= (w_step || !w_run) ? '0 : r_tick + TW'(1);
            r_move_tick <= w_move;
            r_query_hit <= w_query;
            if (w_key_ok) r_next_dir <= w_req_dir;
            if (w_step && w_wall) r_hit_wall <= 1'b1;
            if (w_step && !w_wall && w_body) r_hit_body <= 1'b1;
            if (w_move) begin
                r_cur_dir <= r_next_dir;
                for (int i = 1; i < MAX_LEN; i++) begin
                    r_seg_x[i] <= r_seg_x[i-1];
                    r_seg_y[i] <= r_seg_y[i-1];
                end
                r_seg_x[0] <= w_nx;
                r_seg_y[0] <= w_ny;
                if (r_pending && int'(r_len) < MAX_LEN) r_len <= r_len + LW'(1);
                r_pending <= bus.grow;
            end else begin
                r_pending <= r_pending || bus.grow;
            end
        end
    end

    assign bus.hit_wall  = r_hit_wall;
    assign bus.hit_body  = r_hit_body;
    assign bus.head_x    = r_seg_x[0];
    assign bus.head_y    = r_seg_y[0];
    assign bus.snake_len = r_len;
    assign bus.move_tick = r_move_tick;
    assign bus.query_hit = r_query_hit;
endmodule

// File: tb/tb_snake_motion_ctrl.sv
// tb_snake_motion_ctrl: directed checks of reset, stepping, walls, steering, growth and self-collision
module tb_snake_motion_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fails = 0;
    snake_if #(.XW(6), .YW(5), .LW(5)) bus ();
    snake_motion_ctrl #(.MOVE_TICKS(4)) dut (.CLK_50M(clk), .RST(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fails++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic keys(input logic [3:0] k);
        {bus.key1_press, bus.key2_press, bus.key3_press, bus.key4_press} = k;
        cyc(1);
        {bus.key1_press, bus.key2_press, bus.key3_press, bus.key4_press} = 4'b0000;
    endtask

    task automatic grow_pulse();
        bus.grow = 1'b1;
        cyc(1);
        bus.grow = 1'b0;
    endtask

    task automatic step(output int n);
        n = 0;
        do begin
            cyc(1);
            n++;
        end while (!bus.move_tick && n < 16);
        check("step_seen", bus.move_tick, 1);
    endtask

    task automatic do_restart();
        bus.restart = 1'b1;
        cyc(1);
        bus.restart = 1'b0;
    endtask

    initial begin
        int n;
        int moved;
        bus.game_status = 2'b00;
        bus.restart = 1'b0;
        {bus.key1_press, bus.key2_press, bus.key3_press, bus.key4_press} = 4'b0000;
        bus.grow = 1'b0;
        bus.query_x = 6'd0;
        bus.query_y = 5'd0;
        cyc(2);
        rst = 1'b0;
        check("rst_head_x", bus.head_x, 20);
        check("rst_head_y", bus.head_y, 15);
        check("rst_len", bus.snake_len, 3);
        check("rst_hit_wall", bus.hit_wall, 0);
        check("rst_hit_body", bus.hit_body, 0);
        check("rst_move_tick", bus.move_tick, 0);
        check("rst_query_hit", bus.query_hit, 0);
        bus.query_x = 6'd18;
        bus.query_y = 5'd15;
        cyc(1);
        check("query_tail", bus.query_hit, 1);
        bus.query_x = 6'd17;
        cyc(1);
        check("query_past_tail", bus.query_hit, 0);

        bus.game_status = 2'b10;
        step(n);
        check("step1_x", bus.head_x, 21);
        check("step1_period", n, 4);
        step(n);
        check("step2_x", bus.head_x, 22);
        check("step2_period", n, 4);
        step(n);
        check("step3_x", bus.head_x, 23);
        bus.game_status = 2'b01;
        moved = 0;
        repeat (6) begin
            cyc(1);
            moved |= int'(bus.move_tick);
        end
        check("start_frozen_x", bus.head_x, 23);
        check("start_no_move", moved, 0);
        bus.game_status = 2'b10;
        step(n);
        check("resume_period", n, 4);
        check("resume_x", bus.head_x, 24);

        keys(4'b0010);
        step(n);
        check("reverse_ignored_x", bus.head_x, 25);
        check("reverse_ignored_y", bus.head_y, 15);
        keys(4'b1001);
        step(n);
        check("prio_up_y", bus.head_y, 14);
        check("prio_up_x", bus.head_x, 25);

        do_restart();
        check("rs1_head_x", bus.head_x, 20);
        check("rs1_head_y", bus.head_y, 15);
        for (int i = 0; i < 19; i++) step(n);
        check("wall_edge_x", bus.head_x, 39);
        moved = 0;
        repeat (8) begin
            cyc(1);
            moved |= int'(bus.move_tick);
        end
        check("wall_hit", bus.hit_wall, 1);
        check("wall_stay_x", bus.head_x, 39);
        check("wall_no_move", moved, 0);
        bus.game_status = 2'b11;
        keys(4'b1000);
        cyc(3);
        check("die_sticky_wall", bus.hit_wall, 1);
        check("die_head_y", bus.head_y, 15);

        bus.game_status = 2'b10;
        do_restart();
        grow_pulse();
        cyc(1);
        grow_pulse();
        step(n);
        check("grow_once_len", bus.snake_len, 4);
        step(n);
        check("grow_no_repeat_len", bus.snake_len, 4);
        for (int i = 0; i < 12; i++) begin
            grow_pulse();
            step(n);
        end
        check("grow_max_len", bus.snake_len, 16);
        grow_pulse();
        step(n);
        check("grow_sat_len", bus.snake_len, 16);
        check("grow_sat_x", bus.head_x, 35);

        do_restart();
        grow_pulse();
        step(n);
        grow_pulse();
        step(n);
        check("coll_len", bus.snake_len, 5);
        check("coll_start_x", bus.head_x, 22);
        keys(4'b1000);
        step(n);
        keys(4'b0010);
        step(n);
        keys(4'b0100);
        moved = 0;
        repeat (8) begin
            cyc(1);
            moved |= int'(bus.move_tick);
        end
        check("body_hit", bus.hit_body, 1);
        check("body_no_wall", bus.hit_wall, 0);
        check("body_stay_x", bus.head_x, 21);
        check("body_stay_y", bus.head_y, 14);
        check("body_no_move", moved, 0);
        bus.query_x = 6'd22;
        bus.query_y = 5'd15;
        cyc(1);
        check("query_mid_body", bus.query_hit, 1);
        bus.query_x = 6'd19;
        cyc(1);
        check("query_beyond_len", bus.query_hit, 0);
        bus.query_x = 6'd22;
        cyc(1);
        do_restart();
        check("rs2_head_x", bus.head_x, 20);
        check("rs2_head_y", bus.head_y, 15);
        check("rs2_len", bus.snake_len, 3);
        check("rs2_hit_body", bus.hit_body, 0);
        check("rs2_hit_wall", bus.hit_wall, 0);
        check("rs2_query_hit", bus.query_hit, 0);
        step(n);
        check("rs2_dir_x", bus.head_x, 21);
        check("rs2_dir_y", bus.head_y, 15);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/snake_motion_ctrl.md
Name: snake_motion_ctrl

Overview:
Snake movement and collision engine. It is the counterpart of the game-control FSM: it consumes game_status/restart and the four key pulses, and produces the hit_wall/hit_body events that drive the FSM into DIE. It holds the segment list, steps the snake on a fixed tick during PLAY, and answers one registered per-pixel occupancy query per clock for the VGA renderer.

Parameters:
GRID_W, 40, grid width in cells; x range 0..GRID_W-1
GRID_H, 30, grid height in cells; y range 0..GRID_H-1
MAX_LEN, 16, maximum segment count
INIT_LEN, 3, length after reset/restart; 2..MAX_LEN
MOVE_TICKS, 12_500_000, clocks per step (4 steps/s at 50 MHz)
XW, 6, x coordinate width; must satisfy 2^XW >= GRID_W
YW, 5, y coordinate width; must satisfy 2^YW >= GRID_H
LW, 5, length width; must satisfy 2^LW > MAX_LEN

Ports:
CLK_50M  in  1  system clock
RST  in  1  synchronous, active-high reset
game_status  in  2  00 RESTART, 01 START, 10 PLAY, 11 DIE
restart  in  1  level; while high, re-initialise exactly as RST does
key1_press  in  1  1-cycle pulse: up (y-1)
key2_press  in  1  1-cycle pulse: down (y+1)
key3_press  in  1  1-cycle pulse: left (x-1)
key4_press  in  1  1-cycle pulse: right (x+1)
grow  in  1  1-cycle pulse from apple logic: grow by one on next step
hit_wall  out  1  registered, sticky until RST/restart
hit_body  out  1  registered, sticky until RST/restart
head_x  out  XW  current head x
head_y  out  YW  current head y
snake_len  out  LW  active segment count
move_tick  out  1  1-cycle pulse, high in the cycle the head update becomes visible
query_x  in  XW  renderer pixel cell x
query_y  in  YW  renderer pixel cell y
query_hit  out  1  registered; 1 if the queried cell holds an active segment

Behaviour:
- Init (RST or restart high): seg[i] = (GRID_W/2 - i, GRID_H/2) for i < INIT_LEN; len = INIT_LEN; cur_dir = next_dir = RIGHT; tick_cnt = 0; pending_grow = 0. Outputs: hit_wall = hit_body = move_tick = query_hit = 0; head = (GRID_W/2, GRID_H/2). RST takes priority over all other inputs.
- Direction: key pulses are accepted in every status except DIE. Priority when keys arrive together: key1 > key2 > key3 > key4. A request opposite to cur_dir (the direction of the last committed step) is ignored. An accepted key sets next_dir; the latest accepted key before a step wins. cur_dir <= next_dir at each successful step.
- Tick: tick_cnt increments only while game_status == PLAY and both hit flags are 0; otherwise it is held at 0. When tick_cnt == MOVE_TICKS-1, it wraps to 0 and a step is evaluated on that edge.
- Step evaluation, using next_dir:
  - Wall: if head_x == 0 going left, head_x == GRID_W-1 going right, head_y == 0 going up, or head_y == GRID_H-1 going down, set hit_wall = 1. The snake does not move.
  - Body: the new head is compared against seg[0..len-2]. If pending_grow = 1 and len < MAX_LEN, seg[len-1] is also compared. On any match, set hit_body = 1. The snake does not move.
  - Otherwise: seg[i] <= seg[i-1] for i >= 1; seg[0] <= new head; move_tick = 1 for one cycle.
  - If pending_grow = 1, the step also sets len <= len+1 (saturating at MAX_LEN) and clears pending_grow. At MAX_LEN, pending_grow is cleared and len is unchanged.
- grow: sets pending_grow in any status. Multiple pulses before a step collapse into a single growth. A grow on the same edge as a step applies to the following step.
- Segments with index >= len are don't-care and are never compared.
- query_hit <= OR over i < len of (seg[i] == (query_x, query_y)). Latency is 1 clock, valid in every status.
- Outside PLAY no movement occurs. Segment state and hit flags are frozen through DIE and are cleared only by restart/RST.

Test Plan:
- Sim params: MOVE_TICKS=4, defaults otherwise.
- Reset: assert RST 2 cycles -> head=(20,15), snake_len=3, hit flags 0. With query (18,15) -> query_hit=1 one cycle later; query (17,15) -> 0.
- Stepping: status=PLAY, no keys -> move_tick every 4 clocks; head_x reads 21, 22, 23. Status=START -> head frozen, tick_cnt held at 0.
- Wall: from reset, PLAY with no keys -> 19th step leaves head=(39,15); 20th step sets hit_wall=1, head stays (39,15), move_tick stays 0.
- Reversal and priority: moving right, key3 -> ignored, head_x keeps increasing. key1 and key4 in the same cycle -> up wins, next head_y=14.
- Growth: two grow pulses between steps -> snake_len 3->4 (not 5). A grow pulse at len=MAX_LEN -> snake_len stays 16.
- Self-collision: grow to len 5 while moving right from head (x,15), then steps after key1, key3, key2 -> third step sets hit_body=1, head stays (x-1,14). Then assert restart 1 cycle -> full init values.
